muldiv_unit: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the CPU datapath. It takes the 32x32 multiply and divide work out of the single-cycle ALU and runs it iteratively: shift-add multiply and restoring divide, one bit per cycle. The unit sits beside the ALU in the execute stage and holds the pipeline with `busy` while it runs. It exposes HI/LO for MFHI/MFLO and accepts MTHI/MTLO writes.

---
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply/divide sequencer owning HI/LO
// Signed MULT/DIV (op 2/3) only when MULDIV_SIGNED_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div;
  logic [31:0] opb;
  logic [63:0] acc;
  logic [31:0] rem;

  logic [31:0] x_mag, y_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] res_hi, res_lo;
  logic        res_dz;
  logic        unused_bits;

`ifdef MULDIV_SIGNED_EN
  logic neg_res, neg_rem;

  assign x_mag = (op[1] && X[31]) ? (~X + 32'd1) : X;
  assign y_mag = (op[1] && Y[31]) ? (~Y + 32'd1) : Y;
  assign unused_bits = div_diff[32];
`else
  assign x_mag = X;
  assign y_mag = Y;
  assign unused_bits = div_diff[32] ^ op[1];
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == 5'd31) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // acc[31:0] holds the multiplier (mul) or the dividend/quotient shift register (div)
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
  assign div_shift = {rem, acc[31]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ge    = (div_shift >= {1'b0, opb});

  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
    res_dz = 1'b0;
    if (is_div) begin
      res_hi = rem;
      if (opb == 32'd0) begin
        res_lo = 32'hFFFF_FFFF;
        res_dz = 1'b1;
      end
`ifdef MULDIV_SIGNED_EN
      else begin
        if (neg_res) res_lo = ~acc[31:0] + 32'd1;
        if (neg_rem) res_hi = ~rem + 32'd1;
      end
    end else if (neg_res) begin
      {res_hi, res_lo} = ~acc + 64'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 5'd0;
      is_div   <= 1'b0;
      opb      <= 32'd0;
      acc      <= 64'd0;
      rem      <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= 5'd0;
            is_div <= op[0];
            opb    <= y_mag;
            acc    <= {32'd0, x_mag};
            rem    <= 32'd0;
`ifdef MULDIV_SIGNED_EN
            neg_res <= op[1] & (X[31] ^ Y[31]);
            neg_rem <= op[1] & X[31];
`endif
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            rem       <= div_ge ? div_diff[31:0] : div_shift[31:0];
            acc[31:0] <= {acc[30:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[31:1]};
          end
        end
        S_FIXUP: begin
          hi       <= res_hi;
          lo       <= res_lo;
          done     <= 1'b1;
          div_zero <= res_dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] X = 32'd0;
  logic [31:0] Y = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain 64-bit signed arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bit     sgn;
    longint sx, sy, p, q, r, mag;
    sgn = SIGNED_EN && o[1];
    sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    if (!o[0]) begin
      p = sx * sy;
      return {1'b0, p[63:0]};
    end
    if (y == 32'd0) begin
      mag = (sx < 0) ? -sx : sx;
      return {1'b1, mag[31:0], 32'hFFFF_FFFF};
    end
    q = sx / sy;
    r = sx % sy;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Called in cycle 0 (just after a negedge); returns in cycle 34 with start low.
  // flags[0]: MTHI/MTLO collide with start in cycle 0; flags[1]: start/mthi/X/Y pokes in cycle 5.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input logic [1:0] flags);
    int          bad;
    logic [31:0] pre_hi, pre_lo;
    bad    = 0;
    pre_hi = hi;
    pre_lo = lo;
    start = 1'b1; op = o; X = x; Y = y;
    if (flags[0]) begin mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555_AAAA; end
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    X = $urandom; Y = $urandom; op = 2'($urandom);
    for (int c = 1; c <= 33; c++) begin
      if (flags[1] && c == 5) begin
        start = 1'b1; mthi = 1'b1; wdata = 32'h1234; X = $urandom; Y = $urandom;
      end
      if (c == 6) begin start = 1'b0; mthi = 1'b0; end
      if (!busy || done || div_zero || hi !== pre_hi || lo !== pre_lo) bad++;
      @(negedge clk);
    end
    expect_eq({tag, " run window"}, 64'(bad), 64'd0);
    expect_eq({tag, " busy@34"}, 64'(busy), 64'd0);
    expect_eq({tag, " done@34"}, 64'(done), 64'd1);
    expect_eq({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    expect_eq({tag, " hi"}, 64'(hi), 64'(eh));
    expect_eq({tag, " lo"}, 64'(lo), 64'(el));
  endtask

  task automatic run_model(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] r;
    r = model(o, x, y);
    run_op(tag, o, x, y, r[63:32], r[31:0], r[64], 2'b00);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry, rw;
    int          bad;

    @(negedge clk);
    @(negedge clk);
    expect_eq("reset busy", 64'(busy), 64'd0);
    expect_eq("reset done", 64'(done), 64'd0);
    expect_eq("reset div_zero", 64'(div_zero), 64'd0);
    expect_eq("reset hi", 64'(hi), 64'd0);
    expect_eq("reset lo", 64'(lo), 64'd0);
    rst = 1'b0;

    run_op("multu max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2'b00);
    run_op("divu 100/7", 2'd1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 2'b00);
    run_op("divu 5/0", 2'd1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2'b00);
`ifdef MULDIV_SIGNED_EN
    run_op("mult -3*5", 2'd2, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 2'b00);
    run_op("div -7/2", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 2'b00);
    run_op("div min/-1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 2'b00);
`else
    run_op("op3 unsigned", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 2'b00);
`endif
    @(negedge clk);
    expect_eq("done one-shot", 64'(done), 64'd0);
    expect_eq("div_zero one-shot", 64'(div_zero), 64'd0);

    run_op("multu 6*7 poked", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 2'b10);

    mtlo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    mtlo = 1'b0;
    expect_eq("mtlo lo", 64'(lo), 64'h0000_ABCD);
    expect_eq("mtlo hi kept", 64'(hi), 64'd0);
    mthi = 1'b1; wdata = 32'h0F0F_1234;
    @(negedge clk);
    mthi = 1'b0;
    expect_eq("mthi hi", 64'(hi), 64'h0F0F_1234);
    expect_eq("mthi lo kept", 64'(lo), 64'h0000_ABCD);

    run_op("start beats mt", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 2'b01);

    start = 1'b1; op = 2'd1; X = 32'd1000; Y = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    expect_eq("busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_eq("rst busy", 64'(busy), 64'd0);
    expect_eq("rst hi", 64'(hi), 64'd0);
    expect_eq("rst lo", 64'(lo), 64'd0);
    expect_eq("rst done", 64'(done), 64'd0);
    run_op("after rst", 2'd1, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 2'b00);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = ry >> $urandom_range(1, 31);
        2: rx = 32'h8000_0000;
        3: ry = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (SIGNED_EN && ro == 2'd3 && ry == 32'd0) ry = 32'd1;
      run_model($sformatf("rand%0d op%0d", i, ro), ro, rx, ry);
      if ($urandom_range(0, 3) == 0) begin
        rw = $urandom;
        mthi = 1'b1; mtlo = 1'b1; wdata = rw;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        bad = 0;
        if (hi !== rw) bad++;
        if (lo !== rw) bad++;
        expect_eq($sformatf("rand%0d mt", i), 64'(bad), 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
